systolic_dct_1d_n: RTL and testbench

N-point, parametrised 1-D DCT engine built as a linear systolic chain of N multiply-accumulate PEs. Samples stream in one per beat over a valid/ready handshake. Each PE j accumulates x[k]·C[j][k] for its own output coefficient using a host-loadable coefficient matrix. A completed frame is snapshotted into an output buffer and drained serially, again over valid/ready, with scaling and saturation. It succeeds the fixed 4-PE row engine: it adds frame sequencing, backpressure, programmable basis, and rounding/saturation.

---
 rtl/systolic_dct_1d_n.sv | 120 ++++++++++++
 tb/tb_systolic_dct_1d_n.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_dct_1d_n.sv
// systolic_dct_1d_n: N-point 1-D DCT as a linear chain of MAC PEs with a
// programmable basis, frame snapshot buffer and scaled, saturating serial drain.
module systolic_dct_1d_n #(
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int N = 8,
    parameter int FRAC_BITS = 14,
    localparam int IW = $clog2(N),
    localparam int ACC_WIDTH = DATA_WIDTH + COEF_WIDTH + $clog2(N)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         coef_we,
    input  logic [IW-1:0]                coef_row,
    input  logic [IW-1:0]                coef_col,
    input  logic signed [COEF_WIDTH-1:0] coef_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic [IW-1:0]                out_index,
    output logic                         out_last,
    output logic                         busy
);
    localparam logic [IW-1:0] LAST = IW'(N - 1);
    localparam logic signed [ACC_WIDTH-1:0] SMAX = {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SMIN = {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic signed [COEF_WIDTH-1:0] r_coef [N][N];
    logic [IW-1:0]                r_in_idx;
    logic [N-1:0]                 r_sv;
    logic signed [DATA_WIDTH-1:0] r_sd [N];
    logic [IW-1:0]                r_si [N];
    logic signed [ACC_WIDTH-1:0]  r_acc [N];
    logic signed [ACC_WIDTH-1:0]  r_hold [N];
    logic signed [DATA_WIDTH-1:0] r_buf [N];
    logic                         r_full;
    logic [IW-1:0]                r_drain;

    logic signed [ACC_WIDTH-1:0]  w_sum [N];
    logic [N-1:0]                 w_fin;
    logic                         w_hs;
    logic                         w_hs_last;
    logic                         w_stall;
    logic                         w_adv;
    logic                         w_snap;

    function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [ACC_WIDTH-1:0] a);
        logic signed [ACC_WIDTH-1:0] s;
        s = a >>> FRAC_BITS;
        return s > SMAX ? SMAX[DATA_WIDTH-1:0] : s < SMIN ? SMIN[DATA_WIDTH-1:0] : s[DATA_WIDTH-1:0];
    endfunction

    // Each PE restarts its sum on sample index 0 so frames need no explicit clear.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            w_fin[j] = r_sv[j] && r_si[j] == LAST;
            w_sum[j] = (r_si[j] == '0 ? '0 : r_acc[j])
                     + ACC_WIDTH'(r_sd[j]) * ACC_WIDTH'(r_coef[j][r_si[j]]);
        end
    end

    assign w_hs      = r_full && out_ready;
    assign w_hs_last = w_hs && r_drain == LAST;
    assign w_stall   = r_full && !w_hs_last && w_fin[N-1];
    assign w_adv     = !w_stall;
    assign w_snap    = w_adv && w_fin[N-1];

    assign in_ready  = w_adv;
    assign out_valid = r_full;
    assign out_data  = r_buf[r_drain];
    assign out_index = r_drain;
    assign out_last  = r_full && r_drain == LAST;
    assign busy      = |r_sv || r_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < N; j++) begin
                for (int k = 0; k < N; k++) r_coef[j][k] <= '0;
                r_sd[j]   <= '0;
                r_si[j]   <= '0;
                r_acc[j]  <= '0;
                r_hold[j] <= '0;
                r_buf[j]  <= '0;
            end
            r_in_idx <= '0;
            r_sv     <= '0;
            r_full   <= 1'b0;
            r_drain  <= '0;
        end else begin
            if (coef_we) r_coef[coef_row][coef_col] <= coef_data;
            if (in_valid && w_adv) r_in_idx <= r_in_idx == LAST ? '0 : r_in_idx + IW'(1);
            if (w_adv) begin
                r_sv    <= {r_sv[N-2:0], in_valid};
                r_sd[0] <= in_data;
                r_si[0] <= r_in_idx;
                for (int j = 1; j < N; j++) begin
                    r_sd[j] <= r_sd[j-1];
                    r_si[j] <= r_si[j-1];
                end
                for (int j = 0; j < N; j++) begin
                    if (r_sv[j]) r_acc[j] <= w_sum[j];
                    if (w_fin[j]) r_hold[j] <= w_sum[j];
                end
            end
            // Last PE's final sum bypasses its hold register into the snapshot.
            if (w_snap) begin
                for (int j = 0; j < N - 1; j++) r_buf[j] <= sat(r_hold[j]);
                r_buf[N-1] <= sat(w_sum[N-1]);
                r_full     <= 1'b1;
                r_drain    <= '0;
            end else if (w_hs) begin
                r_full  <= !w_hs_last;
                r_drain <= w_hs_last ? '0 : r_drain + IW'(1);
            end
        end
    end
endmodule

// File: tb/tb_systolic_dct_1d_n.sv
// tb_systolic_dct_1d_n: directed frames checked against a frame-level DCT model
// plus literal expectations for each scenario.
module tb_systolic_dct_1d_n;
    localparam int N = 4, DW = 16, CW = 16, FB = 14, IW = 2;

    logic clk = 1'b0, rst = 1'b1, coef_we = 1'b0;
    logic [IW-1:0] coef_row = '0, coef_col = '0;
    logic signed [CW-1:0] coef_data = '0;
    logic in_valid = 1'b0, in_ready;
    logic signed [DW-1:0] in_data = '0;
    logic out_valid, out_ready = 1'b1, out_last, busy;
    logic signed [DW-1:0] out_data;
    logic [IW-1:0] out_index;

    systolic_dct_1d_n #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .N(N), .FRAC_BITS(FB)) dut (
        .clk(clk), .rst(rst), .coef_we(coef_we), .coef_row(coef_row), .coef_col(coef_col),
        .coef_data(coef_data), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {longint v; int idx;} exp_t;
    int n_checks = 0, n_fail = 0;
    longint mc [N][N];
    longint fr [$];
    exp_t expq [$];
    longint rx [$];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint scale(input longint s);
        longint v;
        v = s >>> FB;
        return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
    endfunction

    // Model: collect whole frames, transform with the current basis, queue results.
    always @(negedge clk) begin
        longint s;
        if (rst) begin
            fr.delete();
            expq.delete();
            foreach (mc[a, b]) mc[a][b] = 0;
        end else begin
            if (coef_we) mc[coef_row][coef_col] = coef_data;
            if (in_valid && in_ready) begin
                fr.push_back(in_data);
                if (fr.size() == N) begin
                    for (int j = 0; j < N; j++) begin
                        s = 0;
                        for (int k = 0; k < N; k++) s += fr[k] * mc[j][k];
                        expq.push_back('{scale(s), j});
                    end
                    fr.delete();
                end
            end
            if (out_valid) begin
                if (expq.size() == 0) check("spurious_out_valid", out_valid, 0);
                else begin
                    check("out_data", out_data, expq[0].v);
                    check("out_index", out_index, expq[0].idx);
                    check("out_last", out_last, expq[0].idx == N - 1);
                    if (out_ready) begin
                        rx.push_back(out_data);
                        void'(expq.pop_front());
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wc(input int r, input int c, input int v);
        coef_we = 1'b1;
        coef_row = IW'(r);
        coef_col = IW'(c);
        coef_data = CW'(v);
        tick();
        coef_we = 1'b0;
    endtask

    task automatic set_row(input int r, input int a, input int b, input int c, input int d);
        wc(r, 0, a); wc(r, 1, b); wc(r, 2, c); wc(r, 3, d);
    endtask

    task automatic ident();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) wc(r, c, r == c ? 16384 : 0);
    endtask

    task automatic dct();
        set_row(0, 8192, 8192, 8192, 8192);
        set_row(1, 10703, 4433, -4433, -10703);
        set_row(2, 8192, -8192, -8192, 8192);
        set_row(3, 4433, -10703, 10703, -4433);
    endtask

    task automatic send(input int x, input int gap);
        int cnt;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data = DW'(x);
        cnt = 0;
        while (!in_ready && cnt < 50) begin tick(); cnt++; end
        if (cnt >= 50) check("send_timeout", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send4(input int a, input int b, input int c, input int d, input int gap);
        send(a, gap); send(b, gap); send(c, gap); send(d, gap);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy || expq.size() != 0) && k < 200) begin tick(); k++; end
        if (k >= 200) check("drain_timeout", busy, 0);
        check("busy_idle", busy, 0);
    endtask

    task automatic check_rx(input string nm, input int n, input int e [8]);
        check({nm, "_count"}, rx.size(), n);
        for (int i = 0; i < n; i++)
            if (i < rx.size()) check(nm, rx[i], e[i]);
        rx.delete();
    endtask

    task automatic chk_reset();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_index", out_index, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset();

        ident();
        send4(1, 2, 3, 4, 0);
        k = 0;
        while (!out_valid && k < 20) begin tick(); k++; end
        check("first_out_latency", k, 4);
        wait_idle();
        check_rx("identity", 4, '{1, 2, 3, 4, 0, 0, 0, 0});

        dct();
        send4(100, 100, 100, 100, 0);
        wait_idle();
        check_rx("dct_const", 4, '{200, 0, 0, 0, 0, 0, 0, 0});

        set_row(0, 32767, 32767, 32767, 32767);
        send4(32767, 32767, 32767, 32767, 0);
        wait_idle();
        check_rx("sat_pos", 4, '{32767, 0, 0, 0, 0, 0, 0, 0});
        send4(-32768, -32768, -32768, -32768, 1);
        wait_idle();
        check_rx("sat_neg", 4, '{-32768, 0, 0, 0, 0, 0, 0, 0});

        dct();
        send4(10, 20, 30, 40, 0);
        wait_idle();
        check_rx("dct_floor", 4, '{50, -23, 0, -2, 0, 0, 0, 0});

        ident();
        out_ready = 1'b0;
        send4(11, 12, 13, 14, 0);
        send4(21, 22, 23, 24, 0);
        k = 0;
        while (in_ready && k < 20) begin tick(); k++; end
        check("stall_onset", k, 3);
        repeat (4) begin
            tick();
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            check("stall_out_index", out_index, 0);
        end
        out_ready = 1'b1;
        repeat (3) tick();
        check("last_hs_index", out_index, 3);
        check("last_hs_last", out_last, 1);
        check("last_hs_in_ready", in_ready, 1);
        tick();
        check("resnap_out_valid", out_valid, 1);
        check("resnap_out_index", out_index, 0);
        check("resnap_in_ready", in_ready, 1);
        wait_idle();
        check_rx("backpressure", 8, '{11, 12, 13, 14, 21, 22, 23, 24});

        send(70, 0);
        send(71, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset();
        send4(9, 9, 9, 9, 0);
        wait_idle();
        check_rx("coef_cleared", 4, '{0, 0, 0, 0, 0, 0, 0, 0});
        ident();
        send4(5, 6, 7, 8, 2);
        wait_idle();
        check_rx("after_reset", 4, '{5, 6, 7, 8, 0, 0, 0, 0});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
